// File: rtl/uproc_pkg.sv
// uproc_pkg -- shared definitions for the register-file arbiter slice.
//   state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   R0..R3  : register index constants
//   RO_IDX  : read-only register index; writes to it are rejected
package uproc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

  localparam logic [1:0] RO_IDX = R3;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin pick with its own pointer flop.
// Ports:
//   clk, nReset : clock, asynchronous active-low reset
//   req[1:0]    : candidate requests this cycle
//   upd         : advance the pointer past 'served' at the next edge
//   served      : index of the requester just served
//   gnt         : picked index (valid when gnt_vld)
//   gnt_vld     : at least one candidate present
module rr_arb2 import uproc_pkg::*; (
  input  logic       clk,
  input  logic       nReset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic       gnt,
  output logic       gnt_vld
);

  // ptr_q names the requester that wins a tie; 0 after reset.
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ~served;
  end

  always_comb begin
    gnt_vld = |req;
    if (req == 2'b11) gnt = ptr_q;
    else              gnt = req[1];
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter -- arbitrates two requesters onto one 4-entry register file.
// Optional feature macro: REGARB_LOCK_EN (adds lock0/lock1 grant-hold inputs).
// Ports:
//   clk, nReset          : clock, asynchronous active-low reset
//   req*/we*/sel*/wdata* : per-requester command
//   lock0, lock1         : (REGARB_LOCK_EN only) keep grant across DONE
//   rf_out               : read data from the register file mux
//   RegNum, RegCE, A     : one-hot select, write enable, write data (ACCESS only)
//   ack0, ack1           : one-cycle completion pulse per requester
//   rdata                : last read result
//   err                  : one-cycle pulse when a write to R3 is rejected
//   dbg_state            : current FSM state
//
// Handshake: a requester raises req with we/sel/wdata stable and holds it until
// its ack pulses; the command is consumed in the cycle ack is high, and req may
// be re-asserted with a new command from the very next cycle.
module reg_file_arbiter import uproc_pkg::*; (
  input  logic       clk,
  input  logic       nReset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] sel0,
  input  logic [1:0] sel1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
`ifdef REGARB_LOCK_EN
  input  logic       lock0,
  input  logic       lock1,
`endif
  input  logic [7:0] rf_out,
  output logic [3:0] RegNum,
  output logic       RegCE,
  output logic [7:0] A,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic [1:0] dbg_state
);

  state_t     state_q, state_d;
  logic       win_q, win_d;
  logic       we_q, we_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] wd_q, wd_d;
  logic [7:0] rdata_q, rdata_d;

  logic [1:0] arb_req;
  logic       arb_gnt, arb_vld, ptr_upd;
  logic       grant_en, grant_idx;
  logic       lock_keep;

`ifdef REGARB_LOCK_EN
  // A lock only holds the grant if the winner actually has a new request.
  assign lock_keep = win_q ? (lock1 & req1) : (lock0 & req0);
`else
  assign lock_keep = 1'b0;
`endif

  rr_arb2 u_rr (
    .clk     (clk),
    .nReset  (nReset),
    .req     (arb_req),
    .upd     (ptr_upd),
    .served  (win_q),
    .gnt     (arb_gnt),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wd_d      = wd_q;
    rdata_d   = rdata_q;
    arb_req   = 2'b00;
    ptr_upd   = 1'b0;
    grant_en  = 1'b0;
    grant_idx = 1'b0;
    RegNum    = 4'b0000;
    RegCE     = 1'b0;
    A         = 8'h00;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb_req = {req1, req0};
        if (arb_vld) begin
          grant_en  = 1'b1;
          grant_idx = arb_gnt;
        end
      end
      ST_ACCESS: begin
        RegNum  = 4'b0001 << sel_q;
        RegCE   = we_q & (sel_q != RO_IDX);
        A       = wd_q;
        if (!we_q) rdata_d = rf_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ack0    = ~win_q;
        ack1    = win_q;
        err     = we_q & (sel_q == RO_IDX);
        state_d = ST_IDLE;
        if (lock_keep) begin
          grant_en  = 1'b1;
          grant_idx = win_q;
        end else begin
          ptr_upd = 1'b1;
          // The requester being acked is not a candidate this cycle.
          arb_req = win_q ? {1'b0, req0} : {req1, 1'b0};
          if (arb_vld) begin
            grant_en  = 1'b1;
            grant_idx = arb_gnt;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Latch the winner's command so outputs stay stable even if the
    // requester changes its inputs right after its ack.
    if (grant_en) begin
      state_d = ST_ACCESS;
      win_d   = grant_idx;
      we_d    = grant_idx ? we1    : we0;
      sel_d   = grant_idx ? sel1   : sel0;
      wd_d    = grant_idx ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= R0;
      wd_q    <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
module tb_reg_file_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nReset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [1:0] sel0 = 2'd0, sel1 = 2'd0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00, rf_out = 8'h00;
  logic       lock0 = 1'b0, lock1 = 1'b0;
  logic [3:0] RegNum;
  logic       RegCE, ack0, ack1, err;
  logic [7:0] A, rdata;
  logic [1:0] dbg_state;

  reg_file_arbiter dut (
    .clk(clk), .nReset(nReset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .sel0(sel0), .sel1(sel1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef REGARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .rf_out(rf_out), .RegNum(RegNum), .RegCE(RegCE), .A(A),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model + compare ----------------
  // Transaction schedule: a decision at an edge puts the winner on the bus for
  // one cycle, the following cycle is its ack. Decisions happen at any edge
  // that does not end a bus cycle; the requester being acked is excluded.
  int         m_acc = -1;   // requester on the bus in the coming cycle
  int         m_ack = -1;   // requester acked in the coming cycle
  bit         m_ptr = 1'b0; // tie winner
  logic [7:0] m_rdata = 8'h00;
  bit         c_we = 1'b0;
  logic [1:0] c_sel = 2'd0;
  logic [7:0] c_wd = 8'h00;
  bit         a_we = 1'b0;
  logic [1:0] a_sel = 2'd0;

  always @(posedge clk) begin
    logic [1:0] rq, lk, wev;
    int nacc, nack;
    bit keep;
    logic [3:0] e_num;
    rq   = {req1, req0};
    lk   = {lock1, lock0};
    wev  = {we1, we0};
    keep = 1'b0;
    if (!nReset) begin
      m_acc = -1; m_ack = -1; m_ptr = 1'b0; m_rdata = 8'h00;
    end else begin
      nacc = -1;
      nack = m_acc;
      if (m_acc >= 0) begin
        a_we  = c_we;
        a_sel = c_sel;
        if (!c_we) m_rdata = rf_out;
      end else begin
`ifdef REGARB_LOCK_EN
        if (m_ack >= 0 && lk[m_ack] && rq[m_ack]) keep = 1'b1;
`endif
        if (keep) nacc = m_ack;
        else begin
          if (m_ack >= 0) begin
            m_ptr = (m_ack == 0);
            rq[m_ack] = 1'b0;
          end
          if (rq == 2'b11) nacc = int'(m_ptr);
          else if (rq[0])  nacc = 0;
          else if (rq[1])  nacc = 1;
        end
        if (nacc >= 0) begin
          c_we  = wev[nacc];
          c_sel = (nacc == 1) ? sel1 : sel0;
          c_wd  = (nacc == 1) ? wdata1 : wdata0;
        end
      end
      m_acc = nacc;
      m_ack = nack;
    end
    #1;
    e_num = 4'b0000;
    if (m_acc >= 0) e_num[c_sel] = 1'b1;
    chk("m_regnum", 32'(RegNum), 32'(e_num));
    chk("m_regce",  32'(RegCE),  32'(m_acc >= 0 && c_we && c_sel != 2'd3));
    chk("m_a",      32'(A),      (m_acc >= 0) ? 32'(c_wd) : 32'h0);
    chk("m_ack0",   32'(ack0),   32'(m_ack == 0));
    chk("m_ack1",   32'(ack1),   32'(m_ack == 1));
    chk("m_err",    32'(err),    32'(m_ack >= 0 && a_we && a_sel == 2'd3));
    chk("m_rdata",  32'(rdata),  32'(m_rdata));
  end

  // ---------------- driver tasks ----------------
  task automatic single(input int who, input bit we, input logic [1:0] sel,
                        input logic [7:0] wd, input logic [7:0] rf,
                        input logic [3:0] exp_num, input bit exp_ce,
                        input bit exp_err, input string tag);
    @(negedge clk);
    if (who == 0) begin we0 = we; sel0 = sel; wdata0 = wd; req0 = 1'b1; end
    else          begin we1 = we; sel1 = sel; wdata1 = wd; req1 = 1'b1; end
    rf_out = rf;
    @(posedge clk); #2;
    chk({tag, "_regnum"}, 32'(RegNum), 32'(exp_num));
    chk({tag, "_regce"},  32'(RegCE),  32'(exp_ce));
    chk({tag, "_a"},      32'(A),      32'(wd));
    chk({tag, "_noack"},  32'(ack0 | ack1), 32'h0);
    @(posedge clk); #2;
    chk({tag, "_ack"}, 32'((who == 0) ? ack0 : ack1), 32'h1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (!we) chk({tag, "_rdata"}, 32'(rdata), 32'(rf));
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; rf_out = 8'h00;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    nReset = 1'b0; req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int who_q[$];
    int cyc_q[$];
    int exp_order[4];
    bit act[2];
    int gap[2];
    int wait_c[2];

    // Reset held with req0 pending: everything quiet.
    req0 = 1'b1; we0 = 1'b0; sel0 = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_regnum", 32'(RegNum), 32'h0);
    chk("rst_regce",  32'(RegCE),  32'h0);
    chk("rst_a",      32'(A),      32'h0);
    chk("rst_ack",    32'(ack0 | ack1), 32'h0);
    chk("rst_err",    32'(err),    32'h0);
    chk("rst_rdata",  32'(rdata),  32'h0);
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk); #2;
    chk("rel_noack",  32'(ack0), 32'h0);
    chk("rel_regnum", 32'(RegNum), 32'h1);
    @(posedge clk); #2;
    chk("rel_ack0", 32'(ack0), 32'h1);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);

    single(0, 1'b1, 2'd1, 8'h5A, 8'h00, 4'b0010, 1'b1, 1'b0, "wr");
    single(0, 1'b1, 2'd3, 8'hA5, 8'h00, 4'b1000, 1'b0, 1'b1, "r3wr");
    single(1, 1'b0, 2'd2, 8'h11, 8'h3C, 4'b0100, 1'b0, 1'b0, "rd");
    single(1, 1'b1, 2'd0, 8'h77, 8'hEE, 4'b0001, 1'b1, 1'b0, "wr1");
    chk("rdata_hold", 32'(rdata), 32'h3C);

    // Reset in the middle of an access: no ack, re-arbitrated afterwards.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; sel0 = 2'd2; rf_out = 8'h42;
    @(posedge clk); #2;
    chk("abort_regnum", 32'(RegNum), 32'h4);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    chk("abort_regnum0", 32'(RegNum), 32'h0);
    chk("abort_noack",   32'(ack0), 32'h0);
    chk("abort_rdata",   32'(rdata), 32'h0);
    @(negedge clk);
    nReset = 1'b1;
    @(posedge clk); #2;
    chk("rearb_noack", 32'(ack0), 32'h0);
    @(posedge clk); #2;
    chk("rearb_ack0",  32'(ack0), 32'h1);
    chk("rearb_rdata", 32'(rdata), 32'h42);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);

    // Contention: both held continuously, pointer favours 0 after reset.
    reset_pulse();
    we0 = 1'b0; sel0 = 2'd1; we1 = 1'b0; sel1 = 2'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      if (ack0) begin who_q.push_back(0); cyc_q.push_back(c); end
      if (ack1) begin who_q.push_back(1); cyc_q.push_back(c); end
    end
    exp_order = '{0, 1, 0, 1};
    chk("cont_count", 32'(who_q.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < who_q.size(); i++) begin
      chk("cont_order", 32'(who_q[i]), 32'(exp_order[i]));
      if (i > 0) chk("cont_gap", 32'(cyc_q[i] - cyc_q[i-1]), 32'h2);
    end
    reset_pulse();

`ifdef REGARB_LOCK_EN
    // Locked requester 0 served back-to-back until lock0 drops.
    who_q.delete();
    we0 = 1'b1; sel0 = 2'd0; we1 = 1'b1; sel1 = 2'd1;
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #2;
      if (ack0) who_q.push_back(0);
      if (ack1) who_q.push_back(1);
      @(negedge clk);
      if (ack0 && who_q.size() == 3) begin lock0 = 1'b0; req0 = 1'b0; end
    end
    exp_order = '{0, 0, 0, 1};
    chk("lock_count", 32'(who_q.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < who_q.size(); i++)
      chk("lock_order", 32'(who_q[i]), 32'(exp_order[i]));
    reset_pulse();
`endif

    // Randomized traffic; the compare process checks every cycle.
    act = '{1'b0, 1'b0};
    gap = '{0, 0};
    wait_c = '{0, 0};
    repeat (2000) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        logic ak;
        ak = (r == 0) ? ack0 : ack1;
        if (act[r] && ak) begin
          act[r] = 1'b0;
          gap[r] = $urandom_range(0, 3);
        end else if (act[r]) begin
          wait_c[r]++;
          if (wait_c[r] > 40) begin
            n_checks++;
            $display("FAIL req_timeout: requester %0d got no ack within %0d cycles", r, wait_c[r]);
            act[r] = 1'b0;
            gap[r] = 2;
          end
        end
        if (!act[r]) begin
          if (gap[r] == 0) begin
            act[r] = 1'b1;
            wait_c[r] = 0;
            if (r == 0) begin
              we0 = 1'($urandom_range(0, 1)); sel0 = 2'($urandom_range(0, 3));
              wdata0 = 8'($urandom_range(0, 255)); lock0 = ($urandom_range(0, 2) == 0);
            end else begin
              we1 = 1'($urandom_range(0, 1)); sel1 = 2'($urandom_range(0, 3));
              wdata1 = 8'($urandom_range(0, 255)); lock1 = ($urandom_range(0, 2) == 0);
            end
          end else begin
            gap[r]--;
            if (r == 0) lock0 = 1'b0; else lock1 = 1'b0;
          end
        end
      end
      req0   = act[0];
      req1   = act[1];
      rf_out = 8'($urandom_range(0, 255));
    end

    // ---------------- final report ----------------
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port nReset  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports req0, req1  input  1 each  access request from requester 0/1; held until ack.
REQ-004 SHALL have ports we0, we1  input  1 each  1 = write, 0 = read; stable while req high.
REQ-005 SHALL have ports sel0, sel1  input  2 each  register index 0..3; stable while req high.
REQ-006 SHALL have ports wdata0, wdata1  input  8 each  write data; stable while req high.
REQ-007 SHALL have port rf_out  input  8  read data from the register file mux.
REQ-008 SHALL have port RegNum  output  4  one-hot register select to the register file.
REQ-009 SHALL have port RegCE  output  1  register file write enable.
REQ-010 SHALL have port A  output  8  register file write data.
REQ-011 SHALL have ports ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-012 SHALL have port rdata  output  8  read result, valid when an ack pulses for a read.
REQ-013 SHALL have port err  output  1  one-cycle pulse: write to R3 rejected.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-015 IDLE: any req high -> ACCESS next cycle, winner latched; no req -> stay IDLE.
REQ-016 Arbitration SHALL be round-robin: single req wins; both high -> requester not served last wins; pointer 0 favoured after reset.
REQ-017 ACCESS (exactly one cycle): RegNum = one-hot(sel of winner) (0->0001, 1->0010, 2->0100, 3->1000); A = winner wdata; RegCE = we & (sel != 3).
REQ-018 ACCESS read: rf_out SHALL be captured into rdata at the end of ACCESS.
REQ-019 DONE: ack of winner SHALL pulse for one cycle; err pulses if write to sel 3; rdata holds last read value (unchanged by writes).
REQ-020 DONE: if any req high excluding the requester being acked, SHALL go to ACCESS directly (back-to-back); else IDLE.
REQ-021 Latency: req sampled in cycle N -> RegCE/RegNum in N+1 -> ack in N+2; sustained throughput one access per 2 cycles.
REQ-022 Outside ACCESS, RegNum = 0000, RegCE = 0, A = 0x00.
REQ-023 Requester deasserting req before ack SHALL be an illegal stimulus; behaviour is not guaranteed.
REQ-024 Round-robin pointer SHALL update only in DONE.

Reset
REQ-025 nReset low SHALL immediately force IDLE, RegNum 0000, RegCE 0, A 0x00, ack0/ack1 0, err 0, rdata 0x00, pointer favouring requester 0.
REQ-026 Reset mid-ACCESS SHALL abort the transfer with no ack; the requester re-arbitrates after release.

Configuration
REQ-027 Macro REGARB_LOCK_EN, when defined, SHALL add inputs lock0, lock1 (1 bit each); winner with lock high in DONE SHALL keep the grant (DONE -> ACCESS, same requester) regardless of round-robin, pointer not updated.
REQ-028 Without REGARB_LOCK_EN the lock ports SHALL not exist and arbitration is pure round-robin.

Structure
REQ-029 Shared package uproc_pkg SHALL hold the FSM state enum, register index constants (R0..R3) and the read-only index R3.
REQ-030 One sub-module rr_arb2 (2-way round-robin pick plus pointer) is natural; one-hot decode stays inline.

Verification
REQ-031 Reset: nReset low with req0 high -> all outputs 0, no ack until 2 cycles after release.
REQ-032 Single write: req0, we0=1, sel0=1, wdata0=0x5A -> next cycle RegNum=0010, RegCE=1, A=0x5A; ack0 the cycle after.
REQ-033 Single read: req1, we1=0, sel1=2, rf_out=0x3C -> RegNum=0100, RegCE=0; ack1 with rdata=0x3C.
REQ-034 Contention: req0 and req1 both held -> grants alternate 0,1,0,1 over four accesses, acks 2 cycles apart.
REQ-035 R3 write: req0, we0=1, sel0=3 -> RegNum=1000, RegCE=0, ack0 and err pulse together.
REQ-036 With REGARB_LOCK_EN: req0+lock0 and req1 held -> requester 0 served back-to-back until lock0 drops, then requester 1 next.
